// File: rtl/xgemac_wb_responder.sv
// ---------------------------------------------------------------------------
// xgemac_wb_responder
//   Wishbone classic slave holding the XGEMAC management register map:
//   CONFIG (0x00, RW), INT_PENDING (0x08, RO clear-on-read),
//   INT_STATUS (0x0C, RO live), INT_MASK (0x10, RW). Other addresses read 0,
//   drop writes, and are still acknowledged.
//
// Ports
//   wb_clk_i          Wishbone clock (the only clock)
//   wb_rst_n          synchronous active-low reset
//   wb_cyc_i/stb_i    bus cycle / strobe
//   wb_we_i           1 = write, 0 = read
//   wb_adr_i[7:0]     byte address, word-decoded on [7:2]
//   wb_dat_i[31:0]    write data
//   wb_dat_o[31:0]    read data, valid while wb_ack_o = 1, otherwise 0
//   wb_ack_o          single-cycle acknowledge
//   int_evt_i         one-cycle interrupt event pulses
//   int_status_i      live interrupt status levels
//   cfg_tx_enable_o   CONFIG[0]
//   int_o             registered OR of (INT_PENDING & INT_MASK)
// ---------------------------------------------------------------------------
module xgemac_wb_responder #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned NUM_INT     = 9,
  parameter logic [31:0] CFG_RESET   = 32'h0000_0001
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [7:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_INT-1:0] int_evt_i,
  input  logic [NUM_INT-1:0] int_status_i,
  output logic               cfg_tx_enable_o,
  output logic               int_o
);

  localparam logic [7:0] ADR_CONFIG = 8'h00;
  localparam logic [7:0] ADR_PEND   = 8'h08;
  localparam logic [7:0] ADR_STATUS = 8'h0C;
  localparam logic [7:0] ADR_MASK   = 8'h10;
  localparam logic [7:0] WORD_MASK  = 8'hFC;
  // Counter preload; the WAIT state is never entered when WAIT_STATES = 0.
  localparam logic [3:0] WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         adr_q, adr_d;
  logic               we_q, we_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        config_q, config_d;
  logic [NUM_INT-1:0] pend_q, pend_d;
  logic [NUM_INT-1:0] mask_q, mask_d;
  logic               int_q, int_d;

  logic               req;
  logic [7:0]         rd_word;
  logic [31:0]        rd_mux;
  logic [NUM_INT-1:0] pend_clr;

  assign req = wb_cyc_i & wb_stb_i;

  // Read data is sampled on the edge entering ACK. With no wait states that
  // edge is also the capture edge, so the live bus address is decoded in IDLE.
  assign rd_word = ((state_q == S_IDLE) ? wb_adr_i : adr_q) & WORD_MASK;

  always_comb begin
    rd_mux = 32'h0;
    case (rd_word)
      ADR_CONFIG: rd_mux = config_q;
      ADR_PEND:   rd_mux = 32'(pend_q);
      ADR_STATUS: rd_mux = 32'(int_status_i);
      ADR_MASK:   rd_mux = 32'(mask_q);
      default:    rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    rdata_d  = 32'h0;
    config_d = config_q;
    mask_d   = mask_q;
    pend_clr = '0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d = wb_adr_i;
          we_d  = wb_we_i;
          dat_d = wb_dat_i;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ACK;
            if (!wb_we_i) rdata_d = rd_mux;
          end
        end
      end
      S_WAIT: begin
        // Initiator withdrew the request: abandon it with no side effects.
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          if (!we_q) rdata_d = rd_mux;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        // The ack is already on the bus, so the access completes regardless
        // of what cyc/stb do now.
        state_d = S_IDLE;
        if (we_q) begin
          case (adr_q & WORD_MASK)
            ADR_CONFIG: config_d = dat_q;
            ADR_MASK:   mask_d   = dat_q[NUM_INT-1:0];
            default:    ;
          endcase
        end else if ((adr_q & WORD_MASK) == ADR_PEND) begin
          // Clear only the bits actually reported to the initiator.
          pend_clr = rdata_q[NUM_INT-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new event on the clearing edge survives the clear.
  assign pend_d = (pend_q & ~pend_clr) | int_evt_i;
  assign int_d  = |(pend_q & mask_q);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      adr_q    <= 8'h0;
      we_q     <= 1'b0;
      dat_q    <= 32'h0;
      rdata_q  <= 32'h0;
      config_q <= CFG_RESET;
      pend_q   <= '0;
      mask_q   <= '0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      config_q <= config_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      int_q    <= int_d;
    end
  end

  assign wb_dat_o        = rdata_q;
  assign wb_ack_o        = (state_q == S_ACK);
  assign cfg_tx_enable_o = config_q[0];
  assign int_o           = int_q;

endmodule

// File: doc/xgemac_wb_responder.md
Name: xgemac_wb_responder

Overview:
- Wishbone classic slave register block that services the management accesses issued by the XGEMAC Wishbone initiator (wb driver/generator).
- Holds the MAC configuration register, interrupt pending/status/mask registers, and the interrupt request output.
- Sits in the wb_clk_i domain.
- Serves as a standalone responder for initiator-side bring-up and as the reference register map for the scoreboard.

Parameters:
- WAIT_STATES, 0, extra cycles inserted between request capture and wb_ack_o (0..15)
- NUM_INT, 9, number of interrupt sources (1..32)
- CFG_RESET, 32'h0000_0001, reset value of CONFIG register (bit0 = tx_enable)

Ports:
- wb_clk_i  input  1  Wishbone clock
- wb_rst_n  input  1  synchronous active-low reset, sampled on rising edge of wb_clk_i
- wb_cyc_i  input  1  bus cycle valid
- wb_stb_i  input  1  strobe
- wb_we_i  input  1  1 = write, 0 = read
- wb_adr_i  input  8  byte address; decoded on [7:2], [1:0] ignored
- wb_dat_i  input  32  write data
- wb_dat_o  output  32  read data, valid while wb_ack_o = 1
- wb_ack_o  output  1  single-cycle acknowledge
- int_evt_i  input  NUM_INT  one-cycle interrupt event pulses from MAC
- int_status_i  input  NUM_INT  live status levels
- cfg_tx_enable_o  output  1  CONFIG[0]
- int_o  output  1  interrupt request

Behaviour:
- Reset, when wb_rst_n = 0 at a rising edge:
  - state = IDLE; wb_ack_o = 0; wb_dat_o = 0
  - CONFIG = CFG_RESET; INT_PENDING = 0; INT_MASK = 0
  - int_o = 0; cfg_tx_enable_o = CFG_RESET[0]
- Register map (word offsets):
  - 0x00 CONFIG: RW, 32 bits.
  - 0x08 INT_PENDING: RO, clear-on-read, NUM_INT bits.
  - 0x0C INT_STATUS: RO, live int_status_i.
  - 0x10 INT_MASK: RW, NUM_INT bits.
  - Upper bits of NUM_INT-wide registers read 0.
  - Any other address reads 32'h0; writes to it are dropped; it is still acknowledged.
- FSM states IDLE, WAIT, ACK:
  - IDLE: when wb_cyc_i & wb_stb_i, capture adr/we/dat into request regs. Go to WAIT if WAIT_STATES > 0 (load counter = WAIT_STATES-1), else go to ACK.
  - WAIT: decrement counter each cycle; go to ACK when counter = 0. If wb_cyc_i = 0 or wb_stb_i = 0 in any WAIT cycle, abort to IDLE: no ack, no register side effect.
  - ACK: wb_ack_o = 1 for exactly this cycle. Write commits or read data is driven on wb_dat_o this cycle. Clear-on-read of INT_PENDING is applied at the clock edge ending this cycle. Next state is IDLE unconditionally.
  - If cyc/stb drop during ACK, the access still completes (ack already committed).
- Latency: request sampled in IDLE at cycle N gives wb_ack_o in cycle N+1+WAIT_STATES. The next request can be sampled no earlier than cycle N+2+WAIT_STATES. A request held asserted through ACK is therefore re-captured as a new access in IDLE.
- wb_dat_o:
  - registered; loaded with read data on entry to ACK
  - returns to 0 the cycle after ACK
  - 0 on write acks
- INT_PENDING:
  - bit i sets on int_evt_i[i] = 1, every cycle, in any FSM state
  - read of 0x08 clears exactly the bits returned on wb_dat_o
  - an event in the same cycle as the clearing edge leaves the bit set (set wins)
  - writes to 0x08 are ignored
- int_o: registered OR of (INT_PENDING & INT_MASK); one-cycle delay after pending/mask update.
- cfg_tx_enable_o: updates the cycle after the CONFIG write ack.
- Reset asserted mid-access: FSM to IDLE immediately; no ack issued; an uncommitted write is lost.

Test Plan:
- Reset then read 0x00, WAIT_STATES=0 → wb_ack_o high exactly 1 cycle, 2nd edge after stb sampled; wb_dat_o = 32'h1; cfg_tx_enable_o = 1.
- Write 0x10 = 32'h1FF, pulse int_evt_i = 9'h004 → INT_PENDING = 9'h004; int_o = 1 two cycles after the pulse. Read 0x08 returns 32'h4; a subsequent read returns 0 and int_o falls.
- int_evt_i[3] pulses in the same cycle as the ACK of a 0x08 read that returns bit3 = 1 → bit3 still set; next read returns 32'h8.
- WAIT_STATES=3, write 0x00 = 0, drop wb_stb_i in 2nd WAIT cycle → no wb_ack_o; CONFIG stays 32'h1. Then a full write gives ack in cycle N+4 and cfg_tx_enable_o = 0.
- Read 0x3C (unmapped) and write 0x3C = 32'hDEAD_BEEF → both acked; read returns 32'h0; no register changes.
- wb_rst_n low during WAIT of a write to 0x10 → no ack; INT_MASK = 0 after reset; FSM IDLE; next access completes normally.
